// File: rtl/picorv32_mem_pkg.sv
// Shared types and helpers for the picorv32 native-port memory responder.
// Optional random wait states are enabled by PICORV32_MEMRESP_RANDOM_WAIT_EN.
package picorv32_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [31:0] OOR_RDATA_DEF = 32'hDEAD_BEEF;

   // 33-bit compare so a window ending at 2**32 does not wrap
   function automatic logic in_range(
      input logic [31:0] addr,
      input logic [31:0] base,
      input int          aw
   );
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + (33'd4 << aw);
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/picorv32_memresp_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random wait states.
// Only instantiated when PICORV32_MEMRESP_RANDOM_WAIT_EN is defined.
module picorv32_memresp_lfsr
   import picorv32_mem_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        adv,
   output logic [15:0] lfsr
);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lfsr <= LFSR_SEED;
      end else if (adv) begin
         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/picorv32_mem_responder.sv
// Single-port memory model answering the picorv32 mem_valid/mem_ready port.
// Define PICORV32_MEMRESP_RANDOM_WAIT_EN to add 0..3 random wait states.
module picorv32_mem_responder
   import picorv32_mem_pkg::*;
#(
   parameter int          AW          = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] OOR_RDATA   = OOR_RDATA_DEF
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          mem_valid,
   input  logic          mem_instr,
   input  logic [31:0]   mem_addr,
   input  logic [31:0]   mem_wdata,
   input  logic [3:0]    mem_wstrb,
   output logic          mem_ready,
   output logic [31:0]   mem_rdata,
   input  logic          load_valid,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   output logic          load_ready,
   output logic          oob,
   output logic          proto_err
);

   localparam int DEPTH = 1 << AW;

   logic [31:0]   mem [DEPTH];
   state_t        state;
   logic [4:0]    cnt;
   logic [4:0]    wait_n;
   logic [AW-1:0] a_idx;
   logic          a_rng;
   logic [31:0]   a_wdata;
   logic [3:0]    a_wstrb;
   logic [31:0]   instr_cnt;
   logic [AW-1:0] in_idx;
   logic          in_rng;
   logic [AW-1:0] rd_idx;
   logic          rd_rng;
   logic          accept;
   logic          to_resp;
   logic          unused_ok;

   assign in_idx     = AW'((mem_addr - BASE_ADDR) >> 2);
   assign in_rng     = in_range(mem_addr, BASE_ADDR, AW);
   assign accept     = (state == IDLE) && mem_valid;
   assign load_ready = (state == IDLE) && !mem_valid;

`ifdef PICORV32_MEMRESP_RANDOM_WAIT_EN
   logic [15:0] lfsr;

   picorv32_memresp_lfsr u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .adv    (accept),
      .lfsr   (lfsr)
   );

   assign wait_n    = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
   assign unused_ok = ^{instr_cnt, lfsr[15:2]};
`else
   assign wait_n    = 5'(WAIT_CYCLES);
   assign unused_ok = ^instr_cnt;
`endif

   // Read source: live request when skipping WAIT, latched one otherwise
   assign rd_idx  = (state == IDLE) ? in_idx : a_idx;
   assign rd_rng  = (state == IDLE) ? in_rng : a_rng;
   assign to_resp = (accept && (wait_n == 5'd0)) ||
                    ((state == WAIT) && mem_valid && (cnt == 5'd1));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         mem_ready <= 1'b0;
         mem_rdata <= 32'd0;
         oob       <= 1'b0;
         proto_err <= 1'b0;
         instr_cnt <= 32'd0;
      end else begin
         mem_ready <= to_resp;
         if (to_resp) begin
            mem_rdata <= rd_rng ? mem[rd_idx] : OOR_RDATA;
            if (!rd_rng) oob <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (mem_valid) begin
                  a_idx   <= in_idx;
                  a_rng   <= in_rng;
                  a_wdata <= mem_wdata;
                  a_wstrb <= mem_wstrb;
                  cnt     <= wait_n;
                  state   <= (wait_n == 5'd0) ? RESP : WAIT;
                  if (mem_instr) instr_cnt <= instr_cnt + 32'd1;
               end
            end
            WAIT: begin
               if (!mem_valid) begin
                  state     <= IDLE;
                  proto_err <= 1'b1;
               end else begin
                  cnt <= cnt - 5'd1;
                  if (cnt == 5'd1) state <= RESP;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Core write and preload are exclusive: preload needs IDLE
   always_ff @(posedge clk) begin
      if (resetn) begin
         if ((state == RESP) && a_rng) begin
            for (int b = 0; b < 4; b++) begin
               if (a_wstrb[b]) mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
            end
         end else if (load_valid && load_ready) begin
            mem[load_addr] <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Scoreboard bench for picorv32_mem_responder at WAIT_CYCLES of 1, 0 and 3.
// Default build only (random wait states disabled).
module tb_picorv32_mem_responder;

   logic        clk = 1'b0;
   logic        rstn [3];
   logic        mv   [3];
   logic        mi   [3];
   logic [31:0] ma   [3];
   logic [31:0] wd   [3];
   logic [3:0]  ws   [3];
   logic        rdy  [3];
   logic [31:0] rd   [3];
   logic        lv   [3];
   logic [9:0]  la   [3];
   logic [31:0] ld   [3];
   logic        lr   [3];
   logic        oob  [3];
   logic        perr [3];

   logic [31:0] sbq [3][$];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      picorv32_mem_responder #(
         .AW          (10),
         .BASE_ADDR   (32'h0000_0000),
         .WAIT_CYCLES ((g == 0) ? 1 : (g == 1) ? 0 : 3),
         .OOR_RDATA   (32'hDEAD_BEEF)
      ) u_dut (
         .clk        (clk),
         .resetn     (rstn[g]),
         .mem_valid  (mv[g]),
         .mem_instr  (mi[g]),
         .mem_addr   (ma[g]),
         .mem_wdata  (wd[g]),
         .mem_wstrb  (ws[g]),
         .mem_ready  (rdy[g]),
         .mem_rdata  (rd[g]),
         .load_valid (lv[g]),
         .load_addr  (la[g]),
         .load_data  (ld[g]),
         .load_ready (lr[g]),
         .oob        (oob[g]),
         .proto_err  (perr[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rstn[k] === 1'b1 && rdy[k] === 1'b1) begin
            if (sbq[k].size() == 0) check($sformatf("unexp_ready%0d", k), 1, 0);
            else check($sformatf("rdata%0d", k), rd[k], sbq[k].pop_front());
         end
      end
   end

   task automatic preload(input int k, input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      lv[k] = 1'b1; la[k] = a; ld[k] = d;
      #1 check("load_ready", 32'(lr[k]), 1);
      @(negedge clk);
      lv[k] = 1'b0;
   endtask

   task automatic xact(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp, input int lat);
      int n = 0;
      sbq[k].push_back(exp);
      @(negedge clk);
      mv[k] = 1'b1; mi[k] = (s == 4'd0); ma[k] = a; wd[k] = d; ws[k] = s;
      do begin
         @(negedge clk);
         n++;
      end while (rdy[k] !== 1'b1 && n < 40);
      check("latency", 32'(n), 32'(lat));
      mv[k] = 1'b0; ws[k] = 4'd0;
   endtask

   initial begin
      int n;
      logic [3:0] pat;
      for (int k = 0; k < 3; k++) begin
         rstn[k] = 1'b0; mv[k] = 1'b0; mi[k] = 1'b0; ma[k] = 32'd0;
         wd[k] = 32'd0; ws[k] = 4'd0; lv[k] = 1'b0; la[k] = 10'd0; ld[k] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_ready", 32'(rdy[k]), 0);
         check("rst_rdata", rd[k], 32'd0);
         check("rst_oob", 32'(oob[k]), 0);
         check("rst_perr", 32'(perr[k]), 0);
         rstn[k] = 1'b1;
      end

      // WAIT_CYCLES=1: preload read, byte-strobed write, range edges
      preload(0, 10'd3, 32'h0000_0013);
      xact(0, 32'h0C, 32'h0, 4'h0, 32'h0000_0013, 2);
      @(negedge clk);
      check("rdata_hold", rd[0], 32'h0000_0013);
      check("ready_pulse", 32'(rdy[0]), 0);
      preload(0, 10'd5, 32'h1122_3344);
      xact(0, 32'h14, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344, 2);
      xact(0, 32'h14, 32'h0, 4'h0, 32'h11BB_33DD, 2);
      preload(0, 10'd1023, 32'hCAFE_0001);
      preload(0, 10'd0, 32'h5A5A_5A5A);
      xact(0, 32'hFFC, 32'h0, 4'h0, 32'hCAFE_0001, 2);
      check("oob_clear", 32'(oob[0]), 0);
      xact(0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF, 2);
      check("oob_edge", 32'(oob[0]), 1);
      xact(0, 32'h0, 32'h0, 4'h0, 32'h5A5A_5A5A, 2);
      xact(0, 32'h0001_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2);
      xact(0, 32'h0C, 32'h0, 4'h0, 32'h0000_0013, 2);
      check("oob_sticky", 32'(oob[0]), 1);

      // WAIT_CYCLES=0: single read, then back-to-back with mem_valid held
      preload(1, 10'd0, 32'h0000_0100);
      preload(1, 10'd1, 32'h0000_0101);
      xact(1, 32'h4, 32'h0, 4'h0, 32'h0000_0101, 1);
      sbq[1].push_back(32'h0000_0100);
      sbq[1].push_back(32'h0000_0101);
      @(negedge clk);
      mv[1] = 1'b1; ma[1] = 32'h0; ws[1] = 4'h0;
      pat = 4'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pat[i] = rdy[1];
         if (i == 0) ma[1] = 32'h4;
         if (i == 2) mv[1] = 1'b0;
      end
      check("b2b_pattern", 32'(pat), 32'h5);

      // WAIT_CYCLES=3: abort in WAIT, core-vs-preload conflict, reset
      preload(2, 10'd2, 32'h0000_0022);
      preload(2, 10'd7, 32'h0000_0070);
      preload(2, 10'd9, 32'h0000_0090);
      @(negedge clk);
      mv[2] = 1'b1; ma[2] = 32'h08; wd[2] = 32'h99; ws[2] = 4'hF;
      @(negedge clk);
      @(negedge clk);
      mv[2] = 1'b0; ws[2] = 4'h0;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (rdy[2]) n++;
      end
      check("abort_no_ready", 32'(n), 0);
      check("abort_perr", 32'(perr[2]), 1);
      xact(2, 32'h08, 32'h0, 4'h0, 32'h0000_0022, 4);

      sbq[2].push_back(32'h0000_0022);
      @(negedge clk);
      mv[2] = 1'b1; ma[2] = 32'h08; ws[2] = 4'h0;
      lv[2] = 1'b1; la[2] = 10'd7; ld[2] = 32'h77;
      #1 check("load_conflict", 32'(lr[2]), 0);
      @(negedge clk);
      lv[2] = 1'b0;
      n = 1;
      while (rdy[2] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 4);
      mv[2] = 1'b0;
      xact(2, 32'h1C, 32'h0, 4'h0, 32'h0000_0070, 4);

      @(negedge clk);
      mv[2] = 1'b1; ma[2] = 32'h24; wd[2] = 32'hBAD; ws[2] = 4'hF;
      @(negedge clk);
      rstn[2] = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", 32'(rdy[2]), 0);
      check("rst_mid_perr", 32'(perr[2]), 0);
      rstn[2] = 1'b1; mv[2] = 1'b0; ws[2] = 4'h0;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (rdy[2]) n++;
      end
      check("rst_no_ready", 32'(n), 0);
      xact(2, 32'h24, 32'h0, 4'h0, 32'h0000_0090, 4);

      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) check("sb_left", 32'(sbq[k].size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
